// File: rtl/lock_pkg.sv
// Shared definitions for the combination-lock subsystem:
// code_sender state encoding and default timer settings.
package lock_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_PRESS     = 3'd1;
    localparam logic [2:0] ST_RELEASE   = 3'd2;
    localparam logic [2:0] ST_WAIT_RESP = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        PRESS     = ST_PRESS,
        RELEASE   = ST_RELEASE,
        WAIT_RESP = ST_WAIT_RESP,
        DONE      = ST_DONE
    } send_state_e;

    // Also used by the lock's own timer configuration.
    localparam int HOLD_CYCLES_DEF  = 4;
    localparam int GAP_CYCLES_DEF   = 4;
    localparam int RESP_TIMEOUT_DEF = 16;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/code_sender_if.sv
// Start/busy/done control handshake of the code sender,
// including the code to send and the reported outcome.
interface code_sender_if #(
    parameter int DIGITS = 4,
    parameter int IDX_W  = 3
) ();

    logic                      start;
    logic [DIGITS*IDX_W-1:0]   code;
    logic                      busy;
    logic                      done;
    logic                      success;

    modport master (
        output start,
        output code,
        input  busy,
        input  done,
        input  success
    );

    modport slave (
        input  start,
        input  code,
        output busy,
        output done,
        output success
    );

endinterface

// File: rtl/interval_counter.sv
// Clearable up-counter that saturates at a terminal count;
// tc is high while the count equals term.
module interval_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr,
    input  logic [W-1:0] term,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc = (cnt_q == term);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!tc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/code_sender.sv
// Sends a stored code to the lock switch bank as timed
// press/release pulses, then reports whether the lock opened.
module code_sender
    import lock_pkg::*;
#(
    parameter int NUM_SW       = 8,
    parameter int DIGITS       = 4,
    parameter int IDX_W        = 3,
    parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
    parameter int GAP_CYCLES   = GAP_CYCLES_DEF,
    parameter int RESP_TIMEOUT = RESP_TIMEOUT_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    code_sender_if.slave      ctrl,
    input  logic              locked,
    input  logic              alarm,
    output logic [NUM_SW-1:0] switches
);

    localparam int CNT_W = $clog2(max3(HOLD_CYCLES, GAP_CYCLES,
                                       RESP_TIMEOUT));
    localparam int DCNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    send_state_e             state_q;
    send_state_e             state_d;
    logic [DCNT_W-1:0]       dig_q;
    logic [DCNT_W-1:0]       dig_d;
    logic [DIGITS*IDX_W-1:0] code_q;
    logic [DIGITS*IDX_W-1:0] code_d;
    logic                    succ_q;
    logic                    succ_d;

    logic [CNT_W-1:0]        term;
    logic                    tc;
    logic                    cnt_clr;
    logic                    last_dig;
    logic [IDX_W-1:0]        cur_idx;

    assign last_dig = (dig_q == DCNT_W'(DIGITS - 1));
    assign cur_idx  = code_q[int'(dig_q)*IDX_W +: IDX_W];
    assign cnt_clr  = (state_d != state_q) || (state_q == IDLE);

    always_comb begin
        term = '0;
        unique case (1'b1)
            state_q == PRESS:     term = CNT_W'(HOLD_CYCLES - 1);
            state_q == RELEASE:   term = CNT_W'(GAP_CYCLES - 1);
            state_q == WAIT_RESP: term = CNT_W'(RESP_TIMEOUT - 1);
            default:              term = '0;
        endcase
    end

    interval_counter #(
        .W (CNT_W)
    ) u_ivl (
        .clock   (clock),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .term    (term),
        .tc      (tc)
    );

    // A low alarm ends the sequence before any other transition.
    always_comb begin
        state_d = state_q;
        dig_d   = dig_q;
        code_d  = code_q;
        succ_d  = succ_q;
        unique case (state_q)
            IDLE: begin
                succ_d = 1'b0;
                if (ctrl.start) begin
                    code_d  = ctrl.code;
                    dig_d   = '0;
                    state_d = PRESS;
                end
            end
            PRESS: begin
                if (!alarm) begin
                    state_d = DONE;
                    succ_d  = 1'b0;
                end else if (tc) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                if (!alarm) begin
                    state_d = DONE;
                    succ_d  = 1'b0;
                end else if (tc) begin
                    if (last_dig) begin
                        state_d = WAIT_RESP;
                    end else begin
                        dig_d   = dig_q + 1'b1;
                        state_d = PRESS;
                    end
                end
            end
            WAIT_RESP: begin
                if (!alarm) begin
                    state_d = DONE;
                    succ_d  = 1'b0;
                end else if (!locked) begin
                    state_d = DONE;
                    succ_d  = 1'b1;
                end else if (tc) begin
                    state_d = DONE;
                    succ_d  = 1'b0;
                end
            end
            DONE: begin
                state_d = IDLE;
                succ_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                succ_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            dig_q   <= '0;
            code_q  <= '0;
            succ_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dig_q   <= dig_d;
            code_q  <= code_d;
            succ_q  <= succ_d;
        end
    end

    // Out-of-range indices press nothing.
    always_comb begin
        switches = '0;
        if (state_q == PRESS && int'(cur_idx) < NUM_SW) begin
            switches[cur_idx] = 1'b1;
        end
    end

    assign ctrl.busy    = (state_q != IDLE);
    assign ctrl.done    = (state_q == DONE);
    assign ctrl.success = succ_q;

endmodule

// File: tb/tb_code_sender.sv
// Directed bench for code_sender with a small behavioural lock
// that expects digits 0,1,2,3.
module tb_code_sender;

    logic       clock;
    logic       reset_n;
    logic       locked;
    logic       alarm;
    logic [7:0] switches;

    code_sender_if #(.DIGITS(4), .IDX_W(3)) ctrl ();

    code_sender dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .ctrl     (ctrl),
        .locked   (locked),
        .alarm    (alarm),
        .switches (switches)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int t0     = 0;

    logic       lk_en;
    logic       lk_clr;
    logic       lk_locked;
    logic       lk_alarm;
    int         lk_good;
    logic [7:0] prev_sw;
    logic       ovr_l;
    logic       ovr_a;

    localparam logic [11:0] C0123 = {3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [11:0] C3250 = {3'd3, 3'd2, 3'd5, 3'd0};
    localparam logic [11:0] C1111 = {3'd1, 3'd1, 3'd1, 3'd1};

    assign locked = lk_locked & ovr_l;
    assign alarm  = lk_alarm & ovr_a;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Lock model: a new press must be 1 << (presses seen so far).
    always @(posedge clock) begin
        prev_sw <= switches;
        if (lk_clr) begin
            lk_locked <= 1'b1;
            lk_alarm  <= 1'b1;
            lk_good   <= 0;
        end else if (lk_en && switches != 0 && prev_sw == 0) begin
            if (switches == 8'(1 << lk_good)) begin
                lk_good <= lk_good + 1;
                if (lk_good == 3) lk_locked <= 1'b0;
            end else begin
                lk_alarm <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic lock_clear();
        @(posedge clock);
        #1 lk_clr = 1'b1;
        @(posedge clock);
        #1 lk_clr = 1'b0;
    endtask

    task automatic go(input logic [11:0] c);
        @(posedge clock);
        #1;
        ctrl.start = 1'b1;
        ctrl.code  = c;
        t0 = cyc;
        @(posedge clock);
        #1 ctrl.start = 1'b0;
    endtask

    task automatic walk(input string tag, input logic [11:0] nc,
                        input int chg_at);
        logic [7:0] e;
        for (int i = 0; i < 32; i++) begin
            @(negedge clock);
            if (i == chg_at) ctrl.code = nc;
            e = ((i % 8) < 4) ? 8'(1 << (i / 8)) : 8'h00;
            chk(tag, {24'd0, switches}, {24'd0, e});
        end
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clock);
            if (ctrl.done) begin
                lat = cyc - t0;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lat;
        logic seen;
        logic bad;

        reset_n    = 1'b0;
        ctrl.start = 1'b0;
        ctrl.code  = '0;
        lk_en      = 1'b0;
        lk_clr     = 1'b1;
        ovr_l      = 1'b1;
        ovr_a      = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        lk_clr  = 1'b0;

        @(negedge clock);
        chk("rst switches", {24'd0, switches}, 32'd0);
        chk("rst busy", {31'd0, ctrl.busy}, 32'd0);
        chk("rst done", {31'd0, ctrl.done}, 32'd0);
        chk("rst success", {31'd0, ctrl.success}, 32'd0);

        // Correct code
        lk_en = 1'b1;
        go(C0123);
        walk("ok seq", C0123, -1);
        wait_done(lat);
        chk("ok latency", 32'(lat), 32'd34);
        chk("ok locked", {31'd0, locked}, 32'd0);
        chk("ok success", {31'd0, ctrl.success}, 32'd1);
        chk("ok busy in done", {31'd0, ctrl.busy}, 32'd1);
        @(negedge clock);
        chk("ok done pulse", {31'd0, ctrl.done}, 32'd0);
        chk("ok idle busy", {31'd0, ctrl.busy}, 32'd0);
        lock_clear();

        // Wrong second digit
        go(C3250);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (!alarm) begin
                seen = 1'b1;
                break;
            end
        end
        chk("bad alarm seen", {31'd0, seen}, 32'd1);
        chk("bad 2nd press", {24'd0, switches}, 32'h20);
        @(negedge clock);
        chk("bad sw off", {24'd0, switches}, 32'd0);
        chk("bad done", {31'd0, ctrl.done}, 32'd1);
        chk("bad success", {31'd0, ctrl.success}, 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (switches != 0) bad = 1'b1;
        end
        chk("bad no 3rd press", {31'd0, bad}, 32'd0);
        lk_en = 1'b0;
        lock_clear();

        // No response
        go(C0123);
        wait_done(lat);
        chk("tmo latency", 32'(lat), 32'd49);
        chk("tmo success", {31'd0, ctrl.success}, 32'd0);
        lock_clear();

        // Start held high, code changed mid-sequence
        lk_en = 1'b1;
        @(posedge clock);
        #1;
        ctrl.start = 1'b1;
        ctrl.code  = C0123;
        t0 = cyc;
        @(posedge clock);
        #1;
        walk("hold seq", C1111, 5);
        wait_done(lat);
        lk_en = 1'b0;
        chk("hold latency", 32'(lat), 32'd34);
        chk("hold success", {31'd0, ctrl.success}, 32'd1);
        @(negedge clock);
        chk("hold idle gap", {31'd0, ctrl.busy}, 32'd0);
        @(negedge clock);
        chk("hold restart", {31'd0, ctrl.busy}, 32'd1);
        chk("hold new code", {24'd0, switches}, 32'h02);
        ctrl.start = 1'b0;

        // Reset during the third press
        repeat (17) @(negedge clock);
        chk("rmid 3rd press", {24'd0, switches}, 32'h02);
        #2 reset_n = 1'b0;
        #1;
        chk("rmid switches", {24'd0, switches}, 32'd0);
        chk("rmid busy", {31'd0, ctrl.busy}, 32'd0);
        chk("rmid done", {31'd0, ctrl.done}, 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        lock_clear();
        lk_en = 1'b1;
        go(C0123);
        walk("rmid seq", C0123, -1);
        wait_done(lat);
        chk("rmid latency", 32'(lat), 32'd34);
        chk("rmid success", {31'd0, ctrl.success}, 32'd1);
        lk_en = 1'b0;
        lock_clear();

        // locked and alarm low together in WAIT_RESP
        go(C0123);
        repeat (33) @(negedge clock);
        chk("both not done yet", {31'd0, ctrl.done}, 32'd0);
        ovr_l = 1'b0;
        ovr_a = 1'b0;
        @(negedge clock);
        chk("both done", {31'd0, ctrl.done}, 32'd1);
        chk("both success", {31'd0, ctrl.success}, 32'd0);
        ovr_l = 1'b1;
        ovr_a = 1'b1;
        @(negedge clock);
        chk("both idle", {31'd0, ctrl.busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
